// File: rtl/noc_pkg.sv
// Shared NoC definitions: default node-id, VC-select and flit-count widths plus the descriptor layout.
package noc_pkg;

  localparam int ADDR_W     = 10;
  localparam int VC_W       = 3;
  localparam int FLIT_CNT_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]     src;
    logic [ADDR_W-1:0]     dest;
    logic [FLIT_CNT_W-1:0] num_flits;
  } pkt_desc_t;

  // Packed width of a descriptor {src, dest, num_flits} for arbitrary field widths.
  function automatic int desc_width(input int addr_w, input int flit_cnt_w);
    return addr_w + addr_w + flit_cnt_w;
  endfunction

endpackage

// File: rtl/pkt_desc_fifo.sv
// Single-VC circular descriptor FIFO with head peek; push/pop are pre-qualified by the caller
// but are still guarded against full/empty here.
module pkt_desc_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              push_s;
  logic              pop_s;

  assign push_s = push & (count_r != FULL_CNT);
  assign pop_s  = pop & (count_r != '0);
  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Storage is left unreset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pkt_desc_queue.sv
// Per-VC packet descriptor queue: NUM_VC independent FIFOs with head peek and dequeue.
// Defining PKT_DESC_QUEUE_STATS_EN adds stat_pkts/stat_flits/stat_drops counters.
module pkt_desc_queue #(
  parameter int ADDR_W     = noc_pkg::ADDR_W,
  parameter int FLIT_CNT_W = noc_pkg::FLIT_CNT_W,
  parameter int NUM_VC     = 8,
  parameter int VC_W       = noc_pkg::VC_W,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [VC_W-1:0]       enq_vc,
  input  logic [ADDR_W-1:0]     enq_src,
  input  logic [ADDR_W-1:0]     enq_dest,
  input  logic [FLIT_CNT_W-1:0] enq_num_flits,
  input  logic [VC_W-1:0]       deq_vc,
  input  logic                  deq_en,
  output logic                  first_valid,
  output logic [ADDR_W-1:0]     first_src,
  output logic [ADDR_W-1:0]     first_dest,
  output logic [FLIT_CNT_W-1:0] first_num_flits,
  output logic [NUM_VC-1:0]     vc_nonempty,
  output logic [NUM_VC-1:0]     vc_full,
  output logic                  drop
`ifdef PKT_DESC_QUEUE_STATS_EN
  ,
  output logic [31:0]           stat_pkts,
  output logic [31:0]           stat_flits,
  output logic [15:0]           stat_drops
`endif
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DESC_W = noc_pkg::desc_width(ADDR_W, FLIT_CNT_W);
  localparam logic [VC_W:0]    NUM_VC_L = (VC_W+1)'(NUM_VC);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DESC_W-1:0] enq_desc_s;
  logic [DESC_W-1:0] first_desc_s;
  logic [DESC_W-1:0] head_s [NUM_VC];
  logic [CNT_W-1:0]  count_s [NUM_VC];
  logic [NUM_VC-1:0] nonempty_s;
  logic [NUM_VC-1:0] full_s;
  logic [NUM_VC-1:0] enq_hit_s;
  logic [NUM_VC-1:0] deq_sel_s;
  logic [NUM_VC-1:0] push_s;
  logic [NUM_VC-1:0] pop_s;
  logic              enq_legal_s;
  logic              illegal_enq_s;

  assign enq_desc_s    = {enq_src, enq_dest, enq_num_flits};
  assign enq_legal_s   = ({1'b0, enq_vc} < NUM_VC_L);
  assign illegal_enq_s = enq_valid & ~enq_legal_s;

  // Only indices below NUM_VC can match, so an out-of-range VC never pushes, pops or reads.
  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    assign nonempty_s[g] = (count_s[g] != '0);
    assign full_s[g]     = (count_s[g] == FULL_CNT);
    assign enq_hit_s[g]  = (enq_vc == VC_W'(g));
    assign deq_sel_s[g]  = (deq_vc == VC_W'(g)) & nonempty_s[g];
    assign push_s[g]     = enq_valid & enq_hit_s[g] & ~full_s[g];
    assign pop_s[g]      = deq_en & deq_sel_s[g];

    pkt_desc_fifo #(
      .DATA_W (DESC_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s[g]),
      .pop       (pop_s[g]),
      .push_data (enq_desc_s),
      .head      (head_s[g]),
      .count     (count_s[g])
    );
  end

  // Head mux: selected non-empty VC drives the data, everything else contributes zero.
  always_comb begin
    first_desc_s = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      first_desc_s = first_desc_s | ({DESC_W{deq_sel_s[i]}} & head_s[i]);
    end
  end

  assign enq_ready   = |(enq_hit_s & ~full_s);
  assign first_valid = |deq_sel_s;
  assign {first_src, first_dest, first_num_flits} = first_desc_s;
  assign vc_nonempty = nonempty_s;
  assign vc_full     = full_s;

  // Rejected out-of-range enqueue is reported one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop <= 1'b0;
    end else begin
      drop <= illegal_enq_s;
    end
  end

`ifdef PKT_DESC_QUEUE_STATS_EN
  logic enq_fire_s;
  assign enq_fire_s = enq_valid & enq_ready;

  // Free-running wrap-around counters, updated on the edge that sees the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts  <= 32'd0;
      stat_flits <= 32'd0;
      stat_drops <= 16'd0;
    end else begin
      if (enq_fire_s) begin
        stat_pkts  <= stat_pkts + 32'd1;
        stat_flits <= stat_flits + 32'(enq_num_flits);
      end
      if (illegal_enq_s) begin
        stat_drops <= stat_drops + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pkt_desc_queue.md
Name: pkt_desc_queue

Overview:
- Parametrised successor to the single-register packet descriptor.
- Buffers packet descriptors (src, dest, num_flits) in independent per-VC FIFOs.
- Provides the "first" (peek head) and "dequeue" operations per VC.
- Sits between the traffic source/injection logic and the router input stage, which drains one VC per cycle.

Parameters:
ADDR_W, 10, width of src/dest node ids
FLIT_CNT_W, 16, width of num_flits
NUM_VC, 8, number of virtual channels / independent FIFOs (>=1)
VC_W, 3, width of VC select; must satisfy 2**VC_W >= NUM_VC
DEPTH, 4, entries per VC FIFO (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
enq_valid  in  1  enqueue request
enq_ready  out  1  enqueue accepted this cycle when high with enq_valid
enq_vc  in  VC_W  target VC of enqueue
enq_src  in  ADDR_W  packet source
enq_dest  in  ADDR_W  packet destination
enq_num_flits  in  FLIT_CNT_W  packet length in flits
deq_vc  in  VC_W  VC selected for first/dequeue
deq_en  in  1  pop head of deq_vc
first_valid  out  1  head of deq_vc present
first_src  out  ADDR_W  head src of deq_vc
first_dest  out  ADDR_W  head dest of deq_vc
first_num_flits  out  FLIT_CNT_W  head length of deq_vc
vc_nonempty  out  NUM_VC  per-VC not-empty
vc_full  out  NUM_VC  per-VC full
drop  out  1  one-cycle pulse: enqueue rejected as illegal

Behaviour:
- Reset (async, while rst=1):
  - All pointers and counts go to 0.
  - vc_nonempty=0, vc_full=0, first_valid=0, drop=0.
  - first_* data=0.
  - Storage contents are don't-care.
- Per-VC FIFO: circular buffer, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- enq_ready is combinational from current state and enq_vc only:
  - 1 iff enq_vc<NUM_VC and count[enq_vc]<DEPTH.
  - It does not depend on deq_en, so a full VC rejects even if popped in the same cycle.
- Enqueue fires when enq_valid && enq_ready. The entry is written at wr_ptr[enq_vc] and the pointer/count are updated on the clock edge.
- Illegal enqueue: enq_valid && enq_vc>=NUM_VC. Nothing is stored; drop=1 on the next cycle (registered), else 0.
- Enqueue to a full legal VC: not accepted, no drop; the producer holds.
- num_flits=0 is stored as-is; no length checking.
- first_* reads are combinational:
  - Data is the head entry of deq_vc; first_valid=count[deq_vc]!=0.
  - When deq_vc>=NUM_VC: first_valid=0 and data=0.
  - When not valid, first_* data is 0.
- Dequeue fires when deq_en && first_valid; rd_ptr and count update on the edge.
  - deq_en on an empty or illegal VC is ignored with no state change.
- Latency: no bypass. An entry written at edge N is visible on first_* after edge N, i.e. in cycle N+1.
  - On an empty VC, a same-cycle enq+deq does not return the new entry.
- Simultaneous enq and deq on the same VC (non-full, non-empty): both fire, count unchanged, pointers both advance.
- Simultaneous enq and deq on different VCs: fully independent.
- Ordering: strict FIFO within a VC; no ordering relation across VCs.
- vc_nonempty[i]=count[i]!=0 and vc_full[i]=count[i]==DEPTH; both are derived from registered count.
- Reset asserted mid-operation flushes all queued descriptors immediately.

Optional Feature:
- Macro: PKT_DESC_QUEUE_STATS_EN.
- When defined, add outputs:
  - stat_pkts (32b): count of accepted enqueues.
  - stat_flits (32b): sum of enq_num_flits over accepted enqueues.
  - stat_drops (16b): count of drop events.
- All three counters reset to 0, wrap modulo 2^width and update on the same edge as the event.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package noc_pkg: ADDR_W=10, VC_W=3, FLIT_CNT_W=16 constants, plus typedef pkt_desc_t {src, dest, num_flits}.
- Sub-module pkt_desc_fifo: one single-VC FIFO with push/pop/head/count, instantiated NUM_VC times by generate.
- The top level does enq_vc/deq_vc decode and the head mux.

Test Plan:
- Reset: after rst pulse, vc_nonempty=0, first_valid=0 for every deq_vc 0..7, enq_ready=1 for enq_vc 0..7.
- Fill/drain: enqueue (src=1,dest=2,nf=5),(3,4,6),(5,6,7),(7,8,8) to VC2.
  - vc_full[2]=1, enq_ready=0 for VC2.
  - Pop 4 times; first_* returns the same order, then first_valid=0 and vc_nonempty[2]=0.
- Full with same-cycle pop: VC2 full, enq_valid plus deq_en on VC2. The pop fires, the enq is not accepted, count goes to 3; next cycle the enq is accepted.
- Latency: empty VC5, enq (9,10,1) at edge N with deq_vc=5 and deq_en=1. No pop at N; first_valid=1 with src=9 in cycle N+1.
- Illegal VC: with NUM_VC=6, enq_vc=7 enq_valid=1. enq_ready=0, drop=1 for one cycle, no vc_nonempty change; deq_en with deq_vc=7 causes no change.
- Wrap and async reset: push/pop 10 packets through VC0 (pointer wrap), checking order; assert rst mid-stream, asynchronously with no clock edge. vc_nonempty=0 immediately; with STATS_EN, stat_* read 0.
